tap_count_reporter: RTL

Measurement sequencer between the UART receive path, the synchronized delay-line tap vector and the UART transmitter. A received command byte selects one of N tap bits. The block counts how many cycles that tap reads 1 over a fixed gate window, then emits a 5-byte result frame through the `uart_tx` byte handshake. It replaces the free-running selection and counting logic in the top level with a closed-loop, one-request-one-frame protocol.

---
 rtl/tap_report_pkg.sv | 42 ++++
 rtl/tap_sel_mux.sv | 45 ++++
 rtl/tap_count_reporter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/tap_report_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tap_report_pkg
// Purpose  : Shared definitions for the tap count reporter: sequencer state
//            encoding, frame layout constants and a frame byte selector.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package tap_report_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_GATE  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_SEND  = 3'd4,
    ST_WAIT  = 3'd5
  } state_t;

  localparam logic [7:0] HDR_MARK     = 8'h80;
  localparam int         FRAME_BYTES  = 5;
  localparam int         PRIME_CYCLES = 2;
  // Widest tap vector the 7-bit index can address.
  localparam int         MAX_TAPS     = 128;

  // Byte idx of a latched 40-bit frame, header first, count MSB first.
  function automatic logic [7:0] frame_byte(input logic [39:0] frame,
                                            input logic [2:0]  idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = frame[39:32];
      3'd1:    b = frame[31:24];
      3'd2:    b = frame[23:16];
      3'd3:    b = frame[15:8];
      3'd4:    b = frame[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tap_sel_mux.sv
`default_nettype none
// ============================================================================
// Module   : tap_sel_mux
// Purpose  : Registered N:1 tap selector. An index at or beyond N reads 0.
// Ports    : iCLK    - system clock
//            iRESET  - synchronous active-high reset
//            iTAPS   - synchronized tap vector (N bits)
//            sel_r   - registered 7-bit tap index
//            oTAP    - registered selected tap bit
// Revision : 1.0 - initial release
// ============================================================================
module tap_sel_mux
  import tap_report_pkg::*;
#(
  parameter int N = 128
) (
  input  logic         iCLK,
  input  logic         iRESET,
  input  logic [N-1:0] iTAPS,
  input  logic [6:0]   sel_r,
  output logic         oTAP
);

  // Zero-pad to the full index range so out-of-range indices read 0
  // without a separate compare.
  logic [MAX_TAPS-1:0] taps_ext;

  generate
    if (N < MAX_TAPS) begin : g_pad
      assign taps_ext = {{(MAX_TAPS-N){1'b0}}, iTAPS};
    end else begin : g_full
      assign taps_ext = iTAPS;
    end
  endgenerate

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      oTAP <= 1'b0;
    end else begin
      oTAP <= taps_ext[sel_r];
    end
  end

endmodule
`default_nettype wire

// File: rtl/tap_count_reporter.sv
`default_nettype none
// ============================================================================
// Module   : tap_count_reporter
// Purpose  : One-request-one-frame tap measurement sequencer. A command byte
//            selects a tap; the block counts cycles the tap reads 1 over a
//            2^GATE_W-cycle gate and sends a 5-byte frame through uart_tx.
//            Optional macro TAP_REPORT_CONT_EN: after a frame with no pending
//            command, re-measure the same tap and stream frames continuously.
// Ports    : iCLK, iRESET        - clock, synchronous active-high reset
//            iSEL_VALID, iSEL    - command strobe and byte (bits [6:0] index)
//            iTAPS               - synchronized tap vector
//            oTX_DV, oTX_BYTE    - byte handshake to uart_tx
//            iTX_DONE            - uart_tx byte-complete pulse
//            oTAP                - registered selected tap (debug)
//            oBUSY               - high whenever not idle
// Revision : 1.0 - initial release
// ============================================================================
module tap_count_reporter
  import tap_report_pkg::*;
#(
  parameter int N      = 128,
  parameter int GATE_W = 24
) (
  input  logic         iCLK,
  input  logic         iRESET,
  input  logic         iSEL_VALID,
  input  logic [7:0]   iSEL,
  input  logic [N-1:0] iTAPS,
  output logic         oTX_DV,
  output logic [7:0]   oTX_BYTE,
  input  logic         iTX_DONE,
  output logic         oTAP,
  output logic         oBUSY
);

  localparam int                PRIME_W    = (PRIME_CYCLES > 1) ? $clog2(PRIME_CYCLES) : 1;
  localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(PRIME_CYCLES - 1);
  localparam logic [2:0]        LAST_IDX   = 3'(FRAME_BYTES - 1);

  state_t              state, state_nxt;
  logic                restart;     // (re)start a measurement this cycle
  logic [6:0]          new_sel;     // tap index used by that start
  logic [6:0]          sel_r;
  logic                pend_valid;
  logic [6:0]          pend_sel;
  logic [PRIME_W-1:0]  prime_cnt;
  logic [GATE_W-1:0]   gate_cnt;
  logic [31:0]         count;
  logic [39:0]         frame;
  logic [2:0]          idx;
  logic [7:0]          tx_byte;
  logic                sel_msb_unused;

  // Bit 7 of the command carries no meaning.
  assign sel_msb_unused = iSEL[7];

  tap_sel_mux #(.N(N)) u_mux (
    .iCLK   (iCLK),
    .iRESET (iRESET),
    .iTAPS  (iTAPS),
    .sel_r  (sel_r),
    .oTAP   (oTAP)
  );

  always_ff @(posedge iCLK) begin
    if (iRESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    new_sel   = sel_r;
    case (state)
      ST_IDLE, ST_PRIME, ST_GATE: begin
        // A command here starts a run, or abandons the one in progress.
        if (iSEL_VALID) begin
          restart = 1'b1;
          new_sel = iSEL[6:0];
        end else if (state == ST_PRIME && prime_cnt == PRIME_LAST) begin
          state_nxt = ST_GATE;
        end else if (state == ST_GATE && gate_cnt == '0) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: state_nxt = ST_SEND;
      ST_SEND: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (iTX_DONE) begin
          if (idx == LAST_IDX) begin
            // A command arriving on the final done is newer than any pending one.
            if (iSEL_VALID) begin
              restart = 1'b1;
              new_sel = iSEL[6:0];
            end else if (pend_valid) begin
              restart = 1'b1;
              new_sel = pend_sel;
            end else begin
`ifdef TAP_REPORT_CONT_EN
              restart = 1'b1;
              new_sel = sel_r;
`else
              state_nxt = ST_IDLE;
`endif
            end
          end else begin
            state_nxt = ST_SEND;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (restart) state_nxt = ST_PRIME;
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      sel_r      <= '0;
      pend_valid <= 1'b0;
      pend_sel   <= '0;
      prime_cnt  <= '0;
      gate_cnt   <= '0;
      count      <= '0;
      frame      <= '0;
      idx        <= '0;
      tx_byte    <= '0;
    end else if (restart) begin
      sel_r      <= new_sel;
      count      <= '0;
      prime_cnt  <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (iSEL_VALID && (state == ST_LOAD || state == ST_SEND || state == ST_WAIT)) begin
        pend_valid <= 1'b1;
        pend_sel   <= iSEL[6:0];
      end
      case (state)
        ST_PRIME: begin
          prime_cnt <= prime_cnt + PRIME_W'(1);
          gate_cnt  <= '1;            // 2^GATE_W-1 down to 0 inclusive
        end
        ST_GATE: begin
          count    <= count + {31'd0, oTAP};
          gate_cnt <= gate_cnt - GATE_W'(1);
        end
        ST_LOAD: begin
          frame   <= {HDR_MARK | {1'b0, sel_r}, count};
          idx     <= '0;
          tx_byte <= HDR_MARK | {1'b0, sel_r};
        end
        ST_WAIT: begin
          if (iTX_DONE && idx != LAST_IDX) begin
            idx     <= idx + 3'd1;
            tx_byte <= frame_byte(frame, idx + 3'd1);
          end
        end
        default: ;
      endcase
    end
  end

  assign oTX_DV   = (state == ST_SEND);
  assign oTX_BYTE = tx_byte;
  assign oBUSY    = (state != ST_IDLE);

endmodule
`default_nettype wire
